// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction-fetch stage of the pipelined MIPS core
// ============================================================================
// Owns the program counter, talks to instruction memory through a
// request/acknowledge port and loads the IF/ID pipeline register that decode
// consumes. Decode back-pressure is absorbed by a one-entry skid buffer.
// Branch redirects from execute are honoured immediately. If a redirect
// arrives while a fetch is still outstanding, that fetch is drained and its
// data dropped.
//
// Parameters
//   INSTRSIZE   MSB index of instruction / PC / address buses (width = +1)
//   RESET_PC    PC loaded on reset (word aligned)
//
// Ports
//   clk, reset         single rising-edge clock, synchronous active-high reset
//   stall              decode cannot accept; IF/ID holds
//   branch_taken       redirect request from execute (PCSrc)
//   branch_target      redirect address (PCBranch)
//   imem_req/addr      fetch request and word address (addr == pc while req)
//   imem_ack/rdata     one-cycle acknowledge with the instruction word
//   if_id_instr        instruction presented to decode
//   if_id_pc_plus4     fetch address + 4 of that instruction
//   if_id_valid        IF/ID holds a live instruction
//   pc                 current fetch PC
//   state_dbg          FSM state (0 FETCH, 1 FULL, 2 DRAIN)
//
// Optional feature (macro IF_STAGE_PERF_EN)
//   perf_fetched       instructions written into IF/ID with valid=1
//   perf_stall_cycles  cycles in which stall=1
//   Both 32 bits, cleared by reset, wrapping. Without the macro these ports
//   and counters do not exist; fetch behaviour is identical either way.
//
// Memory handshake: imem_req is a level request that stays high, with
// imem_addr stable, until the cycle imem_ack is seen (ack may come in the
// same cycle as the request). A transfer happens in every cycle where
// imem_req && imem_ack; imem_rdata is only looked at in that cycle. The only
// time imem_req drops without an ack is reset.
// ============================================================================
module if_stage #(
    parameter int                 INSTRSIZE = 31,
    parameter logic [INSTRSIZE:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [INSTRSIZE:0]   branch_target,
    output logic                 imem_req,
    output logic [INSTRSIZE:0]   imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTRSIZE:0]   imem_rdata,
    output logic [INSTRSIZE:0]   if_id_instr,
    output logic [INSTRSIZE:0]   if_id_pc_plus4,
    output logic                 if_id_valid,
    output logic [INSTRSIZE:0]   pc,
    output logic [1:0]           state_dbg
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall_cycles
`endif
);

    // ------------------------------------------------------------------------
    // FSM encoding
    //   FETCH : request outstanding at pc
    //   FULL  : skid buffer holds a fetched instruction, no request
    //   DRAIN : redirect seen while a request was pending; wait for its ack
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [INSTRSIZE:0] PC_STEP = (INSTRSIZE+1)'(4);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state;
    logic [INSTRSIZE:0] pc_q;
    logic [INSTRSIZE:0] saved_target;
    logic [INSTRSIZE:0] skid_instr;
    logic [INSTRSIZE:0] skid_pc4;

    // Next-state values
    logic [1:0]         state_n;
    logic [INSTRSIZE:0] pc_n;
    logic [INSTRSIZE:0] saved_target_n;
    logic [INSTRSIZE:0] skid_instr_n;
    logic [INSTRSIZE:0] skid_pc4_n;
    logic [INSTRSIZE:0] if_id_instr_n;
    logic [INSTRSIZE:0] if_id_pc_plus4_n;
    logic               if_id_valid_n;

    // Address arithmetic wraps naturally at the bus width.
    logic [INSTRSIZE:0] pc_plus4;
    assign pc_plus4 = pc_q + PC_STEP;

    // ------------------------------------------------------------------------
    // Outputs derived from state
    // ------------------------------------------------------------------------
    // DRAIN keeps requesting at the old pc: the pc register is only updated
    // once the outstanding transfer has been acknowledged.
    assign imem_req  = (state != ST_FULL);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign state_dbg = state;

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: reset (in the flop block) > branch > stall.
    // ------------------------------------------------------------------------
    always_comb begin
        state_n          = state;
        pc_n             = pc_q;
        saved_target_n   = saved_target;
        skid_instr_n     = skid_instr;
        skid_pc4_n       = skid_pc4;
        if_id_instr_n    = if_id_instr;
        if_id_pc_plus4_n = if_id_pc_plus4;
        if_id_valid_n    = if_id_valid;

        case (state)
            ST_FETCH: begin
                if (branch_taken) begin
                    // The instruction sitting in IF/ID is wrong-path; flush it
                    // regardless of stall.
                    if_id_valid_n = 1'b0;
                    if (imem_ack) begin
                        // Returned word is wrong-path too; go straight to target.
                        pc_n = branch_target;
                    end else begin
                        // Cannot abandon a live request: remember where to go
                        // and let it complete first.
                        saved_target_n = branch_target;
                        state_n        = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_n = pc_plus4;
                    if (stall) begin
                        // Decode is busy: park the word in the skid buffer and
                        // stop requesting until it drains.
                        skid_instr_n = imem_rdata;
                        skid_pc4_n   = pc_plus4;
                        state_n      = ST_FULL;
                    end else begin
                        if_id_instr_n    = imem_rdata;
                        if_id_pc_plus4_n = pc_plus4;
                        if_id_valid_n    = 1'b1;
                    end
                end else if (!stall) begin
                    // Memory still busy and decode took what it had: bubble.
                    if_id_valid_n = 1'b0;
                end
            end

            ST_FULL: begin
                if (branch_taken) begin
                    if_id_valid_n = 1'b0;
                    pc_n          = branch_target;
                    state_n       = ST_FETCH;
                end else if (!stall) begin
                    if_id_instr_n    = skid_instr;
                    if_id_pc_plus4_n = skid_pc4;
                    if_id_valid_n    = 1'b1;
                    state_n          = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                if (branch_taken) begin
                    // Latest redirect wins.
                    if_id_valid_n  = 1'b0;
                    saved_target_n = branch_target;
                end
                if (imem_ack) begin
                    // Old data is dropped. A redirect landing in the same
                    // cycle as the ack is newer than the saved one.
                    pc_n    = branch_taken ? branch_target : saved_target;
                    state_n = ST_FETCH;
                end
            end

            default: begin
                state_n = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_FETCH;
            pc_q           <= RESET_PC;
            saved_target   <= '0;
            skid_instr     <= '0;
            skid_pc4       <= '0;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            state          <= state_n;
            pc_q           <= pc_n;
            saved_target   <= saved_target_n;
            skid_instr     <= skid_instr_n;
            skid_pc4       <= skid_pc4_n;
            if_id_instr    <= if_id_instr_n;
            if_id_pc_plus4 <= if_id_pc_plus4_n;
            if_id_valid    <= if_id_valid_n;
        end
    end

`ifdef IF_STAGE_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    // A live instruction enters IF/ID either straight from memory or out of
    // the skid buffer; a redirect in the same cycle suppresses both.
    logic ifid_load;
    assign ifid_load = !branch_taken && !stall &&
                       (((state == ST_FETCH) && imem_ack) || (state == ST_FULL));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (ifid_load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
